// File: rtl/serial_alu_pkg.sv
// Shared definitions for the serial ALU: datapath width and the ALU select
// codes emitted by the ALU control decoder.
package serial_alu_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_SLTU = 4'b0100,
      ALU_XOR  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_OR   = 4'b1000,
      ALU_AND  = 4'b1001
   } alu_sel_e;

   function automatic logic is_shift(input logic [3:0] s);
      return (s == ALU_SLL) || (s == ALU_SRL) || (s == ALU_SRA);
   endfunction

endpackage

// File: rtl/serial_alu_core.sv
// Single-cycle combinational ALU covering every non-shift operation.
// Unknown select codes fall through to ADD.
module alu_core
   import serial_alu_pkg::*;
(
   input  logic [3:0]        sel,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] out
);

   logic signed [DATA_W-1:0] sa;
   logic signed [DATA_W-1:0] sb;

   assign sa = a;
   assign sb = b;

   always_comb begin
      out = a + b;
      case (alu_sel_e'(sel))
         ALU_SUB:  out = a - b;
         ALU_SLT:  out = {{(DATA_W-1){1'b0}}, (sa < sb)};
         ALU_SLTU: out = {{(DATA_W-1){1'b0}}, (a < b)};
         ALU_XOR:  out = a ^ b;
         ALU_OR:   out = a | b;
         ALU_AND:  out = a & b;
         default:  out = a + b;
      endcase
   end

endmodule

// File: rtl/serial_alu.sv
// Multi-cycle ALU: single-cycle ops through alu_core, shifts retired
// SHIFT_STEP bits per cycle through an iterative accumulator.
module serial_alu #(
   parameter int SHIFT_STEP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  sel,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        zero
);

   import serial_alu_pkg::*;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

   state_e              state;
   state_e              state_nxt;
   alu_sel_e            op;
   logic                fill;
   logic [DATA_W-1:0]   acc;
   logic [SHAMT_W-1:0]  count;

   logic                accept;
   logic                step_en;
   logic [DATA_W-1:0]   core_out;
   logic [DATA_W-1:0]   src_val;
   logic [SHAMT_W-1:0]  src_cnt;
   alu_sel_e            src_op;
   logic                src_fill;
   logic [SHAMT_W-1:0]  amt;
   logic [SHAMT_W-1:0]  cnt_rem;
   logic [DATA_W-1:0]   shifted;

   function automatic logic [DATA_W-1:0] shift_by(
      input logic [DATA_W-1:0]  v,
      input logic [SHAMT_W-1:0] n,
      input alu_sel_e           k,
      input logic               f
   );
      case (k)
         ALU_SLL: shift_by = v << n;
         ALU_SRL: shift_by = v >> n;
         default: shift_by = (v >> n) | ({DATA_W{f}} & ~({DATA_W{1'b1}} >> n));
      endcase
   endfunction

   alu_core u_core (
      .sel (sel),
      .a   (a),
      .b   (b),
      .out (core_out)
   );

   // The accept edge already retires the first step, so a shift of N bits
   // completes ceil(N/SHIFT_STEP) edges after it is accepted.
   always_comb begin
      src_val  = (state == IDLE) ? a : acc;
      src_cnt  = (state == IDLE) ? b[SHAMT_W-1:0] : count;
      src_op   = (state == IDLE) ? alu_sel_e'(sel) : op;
      src_fill = (state == IDLE) ? a[DATA_W-1] : fill;
      amt      = (src_cnt < STEP) ? src_cnt : STEP;
      cnt_rem  = src_cnt - amt;
      shifted  = shift_by(src_val, amt, src_op, src_fill);
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      step_en   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = rst;
            if (in_valid && rst) begin
               accept = 1'b1;
               if (is_shift(sel) && (cnt_rem != '0)) state_nxt = SHIFT;
               else                                  state_nxt = DONE;
            end
         end
         SHIFT: begin
            step_en = 1'b1;
            if (cnt_rem == '0) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         op     <= ALU_ADD;
         fill   <= 1'b0;
         acc    <= '0;
         count  <= '0;
         result <= '0;
         zero   <= 1'b1;
      end else if (accept) begin
         op   <= alu_sel_e'(sel);
         fill <= a[DATA_W-1];
         if (is_shift(sel)) begin
            acc   <= shifted;
            count <= cnt_rem;
            if (cnt_rem == '0) begin
               result <= shifted;
               zero   <= (shifted == '0);
            end
         end else begin
            result <= core_out;
            zero   <= (core_out == '0);
         end
      end else if (step_en) begin
         acc   <= shifted;
         count <= cnt_rem;
         if (cnt_rem == '0) begin
            result <= shifted;
            zero   <= (shifted == '0);
         end
      end
   end

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu: two instances (SHIFT_STEP 1 and 4) run the
// same requests and are checked every cycle against an arithmetic model.
module tb_serial_alu;

   import serial_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [3:0]  sel = 4'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;

   logic        ir [2];
   logic        ov [2];
   logic        zr [2];
   logic [31:0] res [2];

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic        rst_q = 1'b1;
   bit          armed = 1'b0;

   bit          busy [2];
   int          done [2];
   logic [31:0] eres [2];
   logic        ezero [2];
   logic [31:0] last_res [2];
   int          steps [2] = '{1, 4};

   serial_alu #(.SHIFT_STEP(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
      .sel(sel), .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready),
      .result(res[0]), .zero(zr[0])
   );

   serial_alu #(.SHIFT_STEP(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
      .sel(sel), .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready),
      .result(res[1]), .zero(zr[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
      logic signed [31:0] sx;
      logic signed [31:0] sy;
      sx = x;
      sy = y;
      case (s)
         4'd1:    return x - y;
         4'd2:    return x << y[4:0];
         4'd3:    return (sx < sy) ? 32'd1 : 32'd0;
         4'd4:    return (x < y) ? 32'd1 : 32'd0;
         4'd5:    return x ^ y;
         4'd6:    return x >> y[4:0];
         4'd7:    return sx >>> y[4:0];
         4'd8:    return x | y;
         4'd9:    return x & y;
         default: return x + y;
      endcase
   endfunction

   function automatic int latency(input logic [3:0] s, input logic [31:0] y, input int st);
      int sh;
      if (!(s == 4'd2 || s == 4'd6 || s == 4'd7)) return 1;
      sh = int'(y[4:0]);
      return (sh == 0) ? 1 : (sh + st - 1) / st;
   endfunction

   // Per-cycle compare of both instances against the model.
   always @(negedge clk) begin
      if (!rst_q) armed = 1'b1;
      if (armed) begin
         for (int k = 0; k < 2; k++) begin
            check1($sformatf("in_ready[%0d]", k), ir[k], rst && !busy[k]);
            if (!rst_q) begin
               check1($sformatf("rst_out_valid[%0d]", k), ov[k], 1'b0);
               check($sformatf("rst_result[%0d]", k), res[k], 32'd0);
               check1($sformatf("rst_zero[%0d]", k), zr[k], 1'b1);
            end else begin
               check1($sformatf("out_valid[%0d]", k), ov[k], busy[k] && (cyc >= done[k]));
               if (ov[k] && busy[k]) begin
                  check($sformatf("result[%0d]", k), res[k], eres[k]);
                  check1($sformatf("zero[%0d]", k), zr[k], ezero[k]);
                  if (out_ready) begin
                     last_res[k] = res[k];
                     busy[k] = 1'b0;
                  end
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (!(ir[0] && ir[1]) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) check("idle_wait", 32'd0, 32'd1);
   endtask

   task automatic accept_op(input logic [3:0] s, input logic [31:0] av, input logic [31:0] bv);
      sel = s; a = av; b = bv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         eres[k]  = model(s, av, bv);
         ezero[k] = (eres[k] == 32'd0);
         done[k]  = cyc + latency(s, bv, steps[k]) - 1;
         busy[k]  = 1'b1;
      end
      sel = 4'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic run_op(input string nm, input logic [3:0] s, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] lit, input int hold);
      int t;
      int hc;
      check({"model_", nm}, model(s, av, bv), lit);
      wait_idle();
      out_ready = (hold == 0);
      accept_op(s, av, bv);
      if (hold > 0) in_valid = 1'b1;
      t = 0;
      hc = 0;
      while ((busy[0] || busy[1]) && t < 200) begin
         if (hold > 0 && ov[0] && ov[1] && !out_ready) begin
            hc++;
            if (hc >= hold) begin
               out_ready = 1'b1;
               in_valid  = 1'b0;
            end
         end
         @(posedge clk); #1;
         t++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (t >= 200) begin
         check({"done_wait_", nm}, 32'd0, 32'd1);
         busy[0] = 1'b0;
         busy[1] = 1'b0;
      end else begin
         for (int k = 0; k < 2; k++)
            check($sformatf("lit_%s[%0d]", nm, k), last_res[k], lit);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      run_op("add_wrap", ALU_ADD,  32'hFFFF_FFFF, 32'd1,          32'h0000_0000, 0);
      run_op("slt",      ALU_SLT,  32'hFFFF_FFFF, 32'd0,          32'h0000_0001, 0);
      run_op("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'd0,          32'h0000_0000, 0);
      run_op("sra31",    ALU_SRA,  32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 0);
      run_op("sll0",     ALU_SLL,  32'h1234_5678, 32'h0000_0020,  32'h1234_5678, 0);
      run_op("srl_hold", ALU_SRL,  32'h0000_00F0, 32'd4,          32'h0000_000F, 5);
      run_op("sub",      ALU_SUB,  32'd5,         32'd7,          32'hFFFF_FFFE, 0);
      run_op("xor",      ALU_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  32'hFF00_FF00, 0);
      run_op("or",       ALU_OR,   32'h0000_0F00, 32'h0000_00F0,  32'h0000_0FF0, 0);
      run_op("and",      ALU_AND,  32'hFF00_FF00, 32'h0F0F_0F0F,  32'h0F00_0F00, 0);
      run_op("undef",    4'hF,     32'd3,         32'd4,          32'h0000_0007, 0);
      run_op("sll_hib",  ALU_SLL,  32'd1,         32'hFFFF_FFE5,  32'h0000_0020, 0);
      run_op("sra4",     ALU_SRA,  32'h8000_0000, 32'd4,          32'hF800_0000, 0);
      run_op("srl31",    ALU_SRL,  32'h8000_0000, 32'd31,         32'h0000_0001, 0);
      run_op("slt_pos",  ALU_SLT,  32'd1,         32'hFFFF_FFFF,  32'h0000_0000, 0);
      run_op("sltu_pos", ALU_SLTU, 32'd1,         32'hFFFF_FFFF,  32'h0000_0001, 0);

      // Reset during the third SHIFT cycle of SLL by 20 abandons the shift.
      wait_idle();
      accept_op(ALU_SLL, 32'h0000_0001, 32'd20);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      busy[0] = 1'b0;
      busy[1] = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("abort_result[%0d]", k), res[k], 32'd0);
         check1($sformatf("abort_zero[%0d]", k), zr[k], 1'b1);
         check1($sformatf("abort_out_valid[%0d]", k), ov[k], 1'b0);
         check1($sformatf("abort_in_ready[%0d]", k), ir[k], 1'b0);
      end
      rst = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      run_op("post_rst", ALU_ADD, 32'd2, 32'd3, 32'h0000_0005, 0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
